// File: rtl/mem_responder.sv
// Multi-channel memory responder: each channel runs an IDLE/WAIT/RESPOND FSM that
// services one read or write after LATENCY cycles against a shared, reset-cleared array.
module mem_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 16,
    parameter int NUM_CHANNELS = 1,
    parameter int LATENCY      = 2,
    parameter int WRITE_ENABLE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] mem_read_valid,
    input  logic [ADDR_BITS-1:0]    mem_read_address  [NUM_CHANNELS-1:0],
    output logic [NUM_CHANNELS-1:0] mem_read_ready,
    output logic [DATA_BITS-1:0]    mem_read_data     [NUM_CHANNELS-1:0],
    input  logic [NUM_CHANNELS-1:0] mem_write_valid,
    input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS-1:0],
    input  logic [DATA_BITS-1:0]    mem_write_data    [NUM_CHANNELS-1:0],
    output logic [NUM_CHANNELS-1:0] mem_write_ready,
    output logic [1:0]              dbg_state_o       [NUM_CHANNELS-1:0]
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CNT_W = $clog2(LATENCY + 1);

    // Handshake: a request is captured in IDLE and its valid must stay high until
    // ready is seen; dropping valid in WAIT aborts, dropping it in RESPOND completes.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_e;

    state_e                 state_q [NUM_CHANNELS-1:0];
    state_e                 state_d [NUM_CHANNELS-1:0];
    logic [CNT_W-1:0]       cnt_q   [NUM_CHANNELS-1:0];
    logic [CNT_W-1:0]       cnt_d   [NUM_CHANNELS-1:0];
    logic [ADDR_BITS-1:0]   addr_q  [NUM_CHANNELS-1:0];
    logic [ADDR_BITS-1:0]   addr_d  [NUM_CHANNELS-1:0];
    logic [DATA_BITS-1:0]   wdata_q [NUM_CHANNELS-1:0];
    logic [DATA_BITS-1:0]   wdata_d [NUM_CHANNELS-1:0];
    logic [DATA_BITS-1:0]   rdata_q [NUM_CHANNELS-1:0];
    logic [DATA_BITS-1:0]   rdata_d [NUM_CHANNELS-1:0];
    logic [NUM_CHANNELS-1:0] is_wr_q, is_wr_d;
    logic [NUM_CHANNELS-1:0] rready_q, rready_d;
    logic [NUM_CHANNELS-1:0] wready_q, wready_d;
    logic [NUM_CHANNELS-1:0] commit_wr;
    logic [NUM_CHANNELS-1:0] orig_valid;
    logic [DATA_BITS-1:0]   mem_q   [DEPTH-1:0];

    assign orig_valid = (is_wr_q & mem_write_valid) | (~is_wr_q & mem_read_valid);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        is_wr_d   = is_wr_q;
        rready_d  = rready_q;
        wready_d  = wready_q;
        commit_wr = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (mem_read_valid[i]) begin
                        addr_d[i]  = mem_read_address[i];
                        is_wr_d[i] = 1'b0;
                        cnt_d[i]   = CNT_W'(LATENCY - 1);
                        state_d[i] = WAIT;
                    end else if ((WRITE_ENABLE != 0) && mem_write_valid[i]) begin
                        addr_d[i]  = mem_write_address[i];
                        wdata_d[i] = mem_write_data[i];
                        is_wr_d[i] = 1'b1;
                        cnt_d[i]   = CNT_W'(LATENCY - 1);
                        state_d[i] = WAIT;
                    end
                end
                WAIT: begin
                    if (!orig_valid[i]) begin
                        cnt_d[i]   = '0;
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end else begin
                        state_d[i] = RESPOND;
                        if (is_wr_q[i]) begin
                            wready_d[i]  = 1'b1;
                            commit_wr[i] = 1'b1;
                        end else begin
                            rready_d[i] = 1'b1;
                            // Array still holds pre-edge contents, giving read-old.
                            rdata_d[i]  = mem_q[addr_q[i]];
                        end
                    end
                end
                RESPOND: begin
                    if (!orig_valid[i]) begin
                        rready_d[i] = 1'b0;
                        wready_d[i] = 1'b0;
                        state_d[i]  = IDLE;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                rdata_q[i] <= '0;
            end
            is_wr_q  <= '0;
            rready_q <= '0;
            wready_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            is_wr_q  <= is_wr_d;
            rready_q <= rready_d;
            wready_q <= wready_d;
        end
    end

    // Per-word write port; scanning channels high-to-low leaves the lowest index winning.
    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        logic                 hit;
        logic [DATA_BITS-1:0] wd;

        always_comb begin
            hit = 1'b0;
            wd  = '0;
            for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
                if (commit_wr[i] && (addr_q[i] == ADDR_BITS'(w))) begin
                    hit = 1'b1;
                    wd  = wdata_q[i];
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem_q[w] <= '0;
            end else if (hit) begin
                mem_q[w] <= wd;
            end
        end
    end

    assign mem_read_ready  = rready_q;
    assign mem_write_ready = wready_q;
    assign mem_read_data   = rdata_q;

    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            dbg_state_o[i] = state_q[i];
        end
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, meaning address width; memory depth is 2**ADDR_BITS words.
REQ-002 SHALL have parameter DATA_BITS, default 16, meaning word width.
REQ-003 SHALL have parameter NUM_CHANNELS, default 1, meaning the number of independent request channels.
REQ-004 SHALL have parameter LATENCY, default 2, legal range >= 1, meaning the number of access cycles per request.
REQ-005 SHALL have parameter WRITE_ENABLE, default 1, meaning writes are permitted when 1 and the memory is read-only when 0.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
REQ-008 SHALL have port mem_read_valid, input, [NUM_CHANNELS-1:0], a per-channel read request.
REQ-009 SHALL have port mem_read_address, input, unpacked array [NUM_CHANNELS-1:0] of ADDR_BITS, the read address.
REQ-010 SHALL have port mem_read_ready, output, [NUM_CHANNELS-1:0], read response valid.
REQ-011 SHALL have port mem_read_data, output, unpacked array [NUM_CHANNELS-1:0] of DATA_BITS, the read response word.
REQ-012 SHALL have port mem_write_valid, input, [NUM_CHANNELS-1:0], a per-channel write request.
REQ-013 SHALL have port mem_write_address, input, unpacked [NUM_CHANNELS-1:0] of ADDR_BITS.
REQ-014 SHALL have port mem_write_data, input, unpacked [NUM_CHANNELS-1:0] of DATA_BITS.
REQ-015 SHALL have port mem_write_ready, output, [NUM_CHANNELS-1:0], write acknowledge.

Function
REQ-016 SHALL hold a storage array of 2**ADDR_BITS words of DATA_BITS, shared by all channels.
REQ-017 SHALL run one independent FSM per channel with states IDLE, WAIT and RESPOND.
REQ-018 SHALL, in IDLE on an edge with mem_read_valid[i]=1, latch the address, mark the request as a read, load counter=LATENCY-1 and enter WAIT.
REQ-019 SHALL, in IDLE with mem_write_valid[i]=1 and mem_read_valid[i]=0 and WRITE_ENABLE=1, latch address and data, mark the request as a write, load counter=LATENCY-1 and enter WAIT.
REQ-020 SHALL give read priority when read and write valid are both high on the same channel; the write SHALL be ignored until the channel returns to IDLE.
REQ-021 SHALL, when WRITE_ENABLE=0, ignore mem_write_valid entirely: no storage change and mem_write_ready permanently 0.
REQ-022 SHALL, in WAIT with counter!=0, decrement the counter by 1 per cycle.
REQ-023 SHALL, in WAIT with counter==0, perform the access, set the matching ready to 1 and enter RESPOND; ready is therefore high LATENCY edges after the accepting edge.
REQ-024 SHALL, for a read, load mem_read_data[i] on the same edge with the array contents as of before any write committed on that edge (read-old).
REQ-025 SHALL, for a write, commit the latched data into the array on the same edge.
REQ-026 SHALL, in RESPOND, hold ready and data stable while the originating valid stays 1.
REQ-027 SHALL, in RESPOND on an edge with the originating valid=0, clear ready and return to IDLE; a new request is accepted no earlier than the following edge.
REQ-028 SHALL, if the originating valid drops during WAIT, abort: return to IDLE, no array access, no ready pulse.
REQ-029 SHALL, when several channels commit writes to the same address on one edge, keep only the lowest-index channel's data.
REQ-030 SHALL hold mem_read_data at its last value after ready clears.

Reset
REQ-031 SHALL, while reset=0 and asynchronously, force every channel FSM to IDLE, counter to 0, mem_read_ready=0, mem_write_ready=0, mem_read_data=0 and all array words to 0.
REQ-032 SHALL, on reset assertion mid-request, discard the request; no write commits.
REQ-033 SHALL ignore valids sampled on the first edge after reset release only if reset is still 0 at that edge.

Verification
REQ-034 SHALL be verified by a write then read at LATENCY=2: write 0x12 <- 0xBEEF; mem_write_ready rises 2 edges after acceptance; drop valid; read 0x12 -> mem_read_ready after 2 edges with data 0xBEEF.
REQ-035 SHALL be verified by a handshake hold check: keep read valid 5 cycles past ready; ready and data stay stable; ready clears 1 edge after valid drops.
REQ-036 SHALL be verified by a 2-channel collision: both write 0x40 on the same edge (0x1111 ch0, 0x2222 ch1); a later read returns 0x1111.
REQ-037 SHALL be verified by a read/write race: ch0 reads 0x05 (old 0x00AA) while ch1 writes 0x05=0x00BB on the same commit edge; ch0 data=0x00AA, a later read returns 0x00BB.
REQ-038 SHALL be verified by reset and abort: assert reset during WAIT of a write to 0x07=0x1234; ready stays 0 and a later read of 0x07 returns 0x0000; dropping valid in WAIT yields no ready pulse.
REQ-039 SHALL be verified with WRITE_ENABLE=0: a write request never gets mem_write_ready and memory is unchanged.
